// File: rtl/capture_sequencer.sv
// Capture/readout sequencer: arms, waits for a triggered sample, fills a single-port
// RAM with 2**AW consecutive valid samples, then streams them back on valid/ready.
module capture_sequencer #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic          trigger,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_LATCH,
    S_SEND
  } state_e;

  localparam logic [AW-1:0] LAST = '1;
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] ram_addr_q;
  logic          ram_rw_q;
  logic [DW-1:0] ram_wdata_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          done_q;

  // NOTE: every register here, including the RAM-facing ones, takes the synchronous
  // reset; the sample RAM itself lives outside and is never cleared.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_addr_q  <= '0;
      ram_rw_q    <= 1'b1;
      ram_wdata_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_rw_q    <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: the RAM writes on every cycle with ram_rw low, so read is the default
      // and only a registered capture write overrides it.
      ram_rw_q <= 1'b1;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q  <= S_ARMED;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end
        end
        S_ARMED: begin
          if (sample_valid && trigger) begin
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= sample_in;
            wr_ptr_q    <= ONE;
            state_q     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= wr_ptr_q;
            ram_wdata_q <= sample_in;
            wr_ptr_q    <= wr_ptr_q + ONE;
            if (wr_ptr_q == LAST) state_q <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          ram_addr_q <= rd_ptr_q;
          state_q    <= S_RD_WAIT;
        end
        S_RD_WAIT: state_q <= S_RD_LATCH;
        S_RD_LATCH: begin
          out_data_q  <= ram_rdata;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (rd_ptr_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + ONE;
              state_q  <= S_RD_REQ;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_rw    = ram_rw_q;
  assign ram_wdata = ram_wdata_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer with AW=2 (4-deep buffer) and a
// behavioural single-port RAM with registered read data.
module tb_capture_sequencer;
  localparam int AW   = 2;
  localparam int DW   = 8;
  localparam int SIZE = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          arm;
  logic          abort;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          trigger;
  logic [AW-1:0] ram_addr;
  logic          ram_rw;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  capture_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid), .trigger(trigger),
    .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [SIZE];
  always @(posedge clk) begin
    if (ram_rw === 1'b0) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  logic [DW-1:0]    exp_q[$];
  logic [DW-1:0]    rx_q[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW+DW-1:0] wr_log[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  logic busy_at_done = 1'b1;
  logic busy_before_done = 1'b0;
  logic last_busy = 1'b0;
  bit   m_armed = 1'b0;
  int   m_cnt = 0;

  always @(negedge clk) begin
    if (ram_rw === 1'b0) wr_log.push_back({ram_addr, ram_wdata});
    if (out_valid === 1'b1 && out_ready && reset_n && !abort) rx_q.push_back(out_data);
    if (done === 1'b1) begin
      done_cnt++;
      busy_at_done     = busy;
      busy_before_done = last_busy;
    end
    last_busy = busy;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    m_armed = 1'b1;
    m_cnt = 0;
    cyc();
    arm = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input logic trig, input logic vld);
    sample_in = d;
    trigger = trig;
    sample_valid = vld;
    if (vld && m_armed && (m_cnt != 0 || trig)) begin
      exp_q.push_back(d);
      exp_wr.push_back({m_cnt[AW-1:0], d});
      m_cnt++;
      if (m_cnt == SIZE) m_armed = 1'b0;
    end
    cyc();
    sample_valid = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) cyc();
    vectors++;
    if (done_cnt !== d0 + 1) begin
      miscompares++;
      $display("FAIL %s done_count got=%0d exp=%0d", name, done_cnt - d0, 1);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && out_valid !== 1'b1; i++) cyc();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s out_valid_timeout got=%b exp=1", name, out_valid);
    end
  endtask

  task automatic compare_scoreboard(input string name);
    logic [DW-1:0]    e, g;
    logic [AW+DW-1:0] ew, gw;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rx_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s stream_missing got=none exp=%h", name, e);
      end else begin
        g = rx_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL %s stream_data got=%h exp=%h", name, g, e);
        end
      end
    end
    vectors++;
    if (rx_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s stream_extra got=%0d exp=0", name, rx_q.size());
      rx_q.delete();
    end
    while (exp_wr.size() != 0) begin
      ew = exp_wr.pop_front();
      vectors++;
      if (wr_log.size() == 0) begin
        miscompares++;
        $display("FAIL %s ram_write_missing got=none exp=%h", name, ew);
      end else begin
        gw = wr_log.pop_front();
        if (gw !== ew) begin
          miscompares++;
          $display("FAIL %s ram_write addr/data got=%h exp=%h", name, gw, ew);
        end
      end
    end
    vectors++;
    if (wr_log.size() != 0) begin
      miscompares++;
      $display("FAIL %s ram_write_extra got=%0d exp=0", name, wr_log.size());
      wr_log.delete();
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_wr.delete();
    rx_q.delete();
    wr_log.delete();
    m_armed = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) cyc();
    vectors++;
    if ({ram_addr, ram_rw, ram_wdata, out_data, out_valid, busy, done} !==
        {2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got=%h/%b/%h/%h/%b/%b/%b exp=0/1/00/00/0/0/0",
               ram_addr, ram_rw, ram_wdata, out_data, out_valid, busy, done);
    end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_arm();
    send_sample(8'h11, 1'b1, 1'b1);
    send_sample(8'h22, 1'b0, 1'b1);
    send_sample(8'h33, 1'b0, 1'b1);
    send_sample(8'h44, 1'b0, 1'b1);
    wait_done("basic", 100);
    compare_scoreboard("basic");
    vectors++;
    if ({busy_before_done, busy_at_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic busy_around_done got=%b exp=10", {busy_before_done, busy_at_done});
    end
  endtask

  task automatic test_pretrigger_gaps();
    out_ready = 1'b1;
    do_arm();
    send_sample(8'h05, 1'b0, 1'b1);
    send_sample(8'h06, 1'b0, 1'b1);
    vectors++;
    if ({busy, ram_rw} !== 2'b11) begin
      miscompares++;
      $display("FAIL pretrig no_write got=%b exp=11", {busy, ram_rw});
    end
    send_sample(8'hA0, 1'b1, 1'b1);
    vectors++;
    if ({ram_rw, ram_addr, ram_wdata} !== {1'b0, 2'd0, 8'hA0}) begin
      miscompares++;
      $display("FAIL pretrig trigger_write got=%b/%h/%h exp=0/0/a0", ram_rw, ram_addr, ram_wdata);
    end
    for (int i = 1; i < SIZE; i++) begin
      send_sample(8'h00, 1'b0, 1'b0);
      vectors++;
      if (ram_rw !== 1'b1) begin
        miscompares++;
        $display("FAIL gap%0d ram_rw got=%b exp=1", i, ram_rw);
      end
      send_sample(8'hA0 + 8'(i), (i == 2), 1'b1);
    end
    wait_done("pretrig", 100);
    compare_scoreboard("pretrig");
    vectors++;
    if (mem[0] !== 8'hA0) begin
      miscompares++;
      $display("FAIL pretrig mem0 got=%h exp=a0", mem[0]);
    end
  endtask

  task automatic test_read_latency();
    out_ready = 1'b1;
    do_arm();
    send_sample(8'h71, 1'b1, 1'b1);
    send_sample(8'h72, 1'b0, 1'b1);
    send_sample(8'h73, 1'b0, 1'b1);
    send_sample(8'h74, 1'b0, 1'b1);
    cyc();
    vectors++;
    if ({ram_addr, ram_rw, out_valid} !== {2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL latency edge1 got=%h/%b/%b exp=0/1/0", ram_addr, ram_rw, out_valid);
    end
    cyc();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency edge2 out_valid got=%b exp=0", out_valid);
    end
    cyc();
    vectors++;
    if ({out_valid, out_data} !== {1'b1, 8'h71}) begin
      miscompares++;
      $display("FAIL latency edge3 got=%b/%h exp=1/71", out_valid, out_data);
    end
    cyc();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency after_handshake out_valid got=%b exp=0", out_valid);
    end
    cyc();
    vectors++;
    if (ram_addr !== 2'd1) begin
      miscompares++;
      $display("FAIL latency next_addr got=%h exp=1", ram_addr);
    end
    wait_done("latency", 100);
    compare_scoreboard("latency");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_arm();
    send_sample(8'h11, 1'b1, 1'b1);
    send_sample(8'h22, 1'b0, 1'b1);
    send_sample(8'h33, 1'b0, 1'b1);
    send_sample(8'h44, 1'b0, 1'b1);
    wait_valid("backpressure", 20);
    for (int i = 0; i < 10; i++) begin
      cyc();
      vectors++;
      if ({out_valid, out_data, ram_addr} !== {1'b1, exp_q[0], 2'd0} || rx_q.size() != 0) begin
        miscompares++;
        $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/%h/0", i, out_valid, out_data, ram_addr, exp_q[0]);
      end
    end
    out_ready = 1'b1;
    wait_done("backpressure", 100);
    compare_scoreboard("backpressure");
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    do_arm();
    send_sample(8'h61, 1'b1, 1'b1);
    send_sample(8'h62, 1'b0, 1'b1);
    abort = 1'b1;
    arm = 1'b1;
    cyc();
    abort = 1'b0;
    arm = 1'b0;
    vectors++;
    if ({busy, ram_rw, out_valid, done} !== 4'b0100) begin
      miscompares++;
      $display("FAIL abort state got=%b exp=0100", {busy, ram_rw, out_valid, done});
    end
    clear_model();
    repeat (3) cyc();
    vectors++;
    if ({busy, ram_rw} !== 2'b01) begin
      miscompares++;
      $display("FAIL abort idle got=%b exp=01", {busy, ram_rw});
    end
    do_arm();
    for (int i = 0; i < SIZE; i++) send_sample(8'h51 + 8'(i), (i == 0), 1'b1);
    wait_done("rearm", 100);
    compare_scoreboard("rearm");
  endtask

  task automatic test_reset_in_send();
    int d0;
    out_ready = 1'b0;
    do_arm();
    for (int i = 0; i < SIZE; i++) send_sample(8'h81 + 8'(i), (i == 0), 1'b1);
    wait_valid("rst_send", 20);
    reset_n = 1'b0;
    d0 = done_cnt;
    cyc();
    vectors++;
    if ({out_valid, busy, done, ram_rw} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_send state got=%b exp=0001", {out_valid, busy, done, ram_rw});
    end
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) cyc();
    vectors++;
    if ({done_cnt, busy} !== {d0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_send no_done got=%0d/%b exp=%0d/0", done_cnt, busy, d0);
    end
    clear_model();
  endtask

  task automatic test_ignored_arm();
    int d0;
    out_ready = 1'b0;
    do_arm();
    send_sample(8'h91, 1'b1, 1'b1);
    arm = 1'b1;
    send_sample(8'h92, 1'b0, 1'b1);
    arm = 1'b0;
    vectors++;
    if ({ram_rw, ram_addr, ram_wdata} !== {1'b0, 2'd1, 8'h92}) begin
      miscompares++;
      $display("FAIL arm_capture got=%b/%h/%h exp=0/1/92", ram_rw, ram_addr, ram_wdata);
    end
    send_sample(8'h93, 1'b0, 1'b1);
    send_sample(8'h94, 1'b0, 1'b1);
    wait_valid("arm_send", 20);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    cyc();
    vectors++;
    if ({out_valid, out_data, busy} !== {1'b1, 8'h91, 1'b1}) begin
      miscompares++;
      $display("FAIL arm_send hold got=%b/%h/%b exp=1/91/1", out_valid, out_data, busy);
    end
    out_ready = 1'b1;
    wait_done("arm_send", 100);
    compare_scoreboard("arm_send");
    d0 = done_cnt;
    repeat (20) cyc();
    vectors++;
    if ({done_cnt, busy} !== {d0, 1'b0}) begin
      miscompares++;
      $display("FAIL arm_send single_done got=%0d/%b exp=%0d/0", done_cnt, busy, d0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    trigger = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_pretrigger_gaps();
    test_read_latency();
    test_backpressure();
    test_abort();
    test_reset_in_send();
    test_ignored_arm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
